// File: rtl/user_obi_popcount_mgr.sv
// ---------------------------------------------------------------------------
// obi_pkg: minimal OBI configuration and channel types for the user domain.
//
// user_obi_popcount_mgr: OBI manager that reads num_words_i consecutive
// 32-bit words starting at src_addr_i, sums the number of set bits across
// all of them, then writes the 32-bit total to dst_addr_i and pulses done_o.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      start pulse, only sampled while idle
//   src_addr_i   first read address (bits [1:0] forced to zero)
//   dst_addr_i   result write address (bits [1:0] forced to zero)
//   num_words_i  number of words to read, zero allowed
//   busy_o       run in progress
//   done_o       one-cycle completion pulse
//   err_o        error flag of the last run, held until the next start
//   result_o     popcount of the last run, held until the next start
//   obi_req_o    OBI manager request (a channel, req, rready)
//   obi_rsp_i    OBI manager response (gnt, rvalid, r channel)
// ---------------------------------------------------------------------------
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
        bit          UseRReady;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32'd32,
        DataWidth: 32'd32,
        IdWidth:   32'd1,
        UseRReady: 1'b1
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module user_obi_popcount_mgr #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       LenWidth  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [ObiCfg.AddrWidth-1:0]   src_addr_i,
    input  logic [ObiCfg.AddrWidth-1:0]   dst_addr_i,
    input  logic [LenWidth-1:0]           num_words_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [31:0]                   result_o,
    output obi_req_t                      obi_req_o,
    input  obi_rsp_t                      obi_rsp_i
);

    localparam int unsigned AddrWidth = ObiCfg.AddrWidth;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Number of set bits in one data word (0..32).
    function automatic logic [5:0] popcount32(input logic [31:0] word);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, word[i]};
        end
        return cnt;
    endfunction

    state_e                 state_r,  state_s;
    logic [AddrWidth-1:0]   addr_r,   addr_s;
    logic [AddrWidth-1:0]   dst_r,    dst_s;
    logic [LenWidth-1:0]    rem_r,    rem_s;
    logic [31:0]            acc_r,    acc_s;
    logic                   err_r,    err_s;
    logic [31:0]            result_r, result_s;
    logic                   busy_r,   busy_s;
    logic                   done_r,   done_s;
    logic                   req_r,    req_s;
    logic                   we_r,     we_s;
    logic [AddrWidth-1:0]   a_addr_r, a_addr_s;
    logic [31:0]            wdata_r,  wdata_s;
    logic [5:0]             pc_s;

    // Response fields and address LSBs that this manager never looks at.
    logic unused_s;
    assign unused_s = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional,
                        src_addr_i[1:0], dst_addr_i[1:0]};

    // Popcount of the word currently on the response channel.
    always_comb begin
        pc_s = popcount32(obi_rsp_i.r.rdata);
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        dst_s    = dst_r;
        rem_s    = rem_r;
        acc_s    = acc_r;
        err_s    = err_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    addr_s   = {src_addr_i[AddrWidth-1:2], 2'b00};
                    dst_s    = {dst_addr_i[AddrWidth-1:2], 2'b00};
                    rem_s    = num_words_i;
                    acc_s    = 32'd0;
                    err_s    = 1'b0;
                    result_s = 32'd0;
                    if (num_words_i == {LenWidth{1'b0}}) begin
                        state_s = WR_REQ;
                    end else begin
                        state_s = RD_REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (obi_rsp_i.gnt) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        // Abort: remaining reads and the write are skipped.
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        acc_s  = acc_r + {26'd0, pc_s};
                        addr_s = addr_r + AddrWidth'(3'd4);
                        rem_s  = rem_r - LenWidth'(1'b1);
                        if (rem_r == LenWidth'(1'b1)) begin
                            // result_o captures the total on entry to WR_REQ
                            // so it survives an erroring write.
                            result_s = acc_s;
                            state_s  = WR_REQ;
                        end else begin
                            state_s = RD_REQ;
                        end
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (obi_rsp_i.gnt) begin
                    state_s = WR_WAIT;
                end else begin
                    state_s = WR_REQ;
                end
            end
            WR_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    err_s   = obi_rsp_i.r.err;
                    state_s = DONE;
                end else begin
                    state_s = WR_WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output and a-channel values decoded from the next state so that every
    // output comes straight from a flop and lines up with the state register.
    always_comb begin
        req_s    = 1'b0;
        we_s     = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        a_addr_s = addr_s;
        wdata_s  = 32'd0;
        case (state_s)
            IDLE: begin
                busy_s = 1'b0;
            end
            RD_REQ: begin
                req_s  = 1'b1;
                busy_s = 1'b1;
            end
            RD_WAIT: begin
                busy_s = 1'b1;
            end
            WR_REQ: begin
                req_s    = 1'b1;
                we_s     = 1'b1;
                busy_s   = 1'b1;
                a_addr_s = dst_s;
                wdata_s  = acc_s;
            end
            WR_WAIT: begin
                we_s     = 1'b1;
                busy_s   = 1'b1;
                a_addr_s = dst_s;
                wdata_s  = acc_s;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            addr_r   <= {AddrWidth{1'b0}};
            dst_r    <= {AddrWidth{1'b0}};
            rem_r    <= {LenWidth{1'b0}};
            acc_r    <= 32'd0;
            err_r    <= 1'b0;
            result_r <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            req_r    <= 1'b0;
            we_r     <= 1'b0;
            a_addr_r <= {AddrWidth{1'b0}};
            wdata_r  <= 32'd0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            dst_r    <= dst_s;
            rem_r    <= rem_s;
            acc_r    <= acc_s;
            err_r    <= err_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            req_r    <= req_s;
            we_r     <= we_s;
            a_addr_r <= a_addr_s;
            wdata_r  <= wdata_s;
        end
    end

    // Drive the OBI request: rready tied high, unused optional fields zero.
    always_comb begin
        obi_req_o              = '0;
        obi_req_o.req          = req_r;
        obi_req_o.rready       = 1'b1;
        obi_req_o.a.addr       = a_addr_r;
        obi_req_o.a.we         = we_r;
        obi_req_o.a.be         = 4'hF;
        obi_req_o.a.wdata      = wdata_r;
        obi_req_o.a.aid        = '0;
        obi_req_o.a.a_optional = '0;
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign err_o    = err_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_user_obi_popcount_mgr.sv
// ---------------------------------------------------------------------------
// Directed testbench for user_obi_popcount_mgr. A small OBI subordinate model
// serves a fixed word memory, can stall gnt, inject an error on a chosen
// handshake, and logs every accepted request for later comparison.
// ---------------------------------------------------------------------------
module tb_user_obi_popcount_mgr;

    logic              clk;
    logic              rst_ni;
    logic              start_i;
    logic [31:0]       src_addr_i;
    logic [31:0]       dst_addr_i;
    logic [15:0]       num_words_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       result_o;
    obi_pkg::obi_req_t obi_req;
    obi_pkg::obi_rsp_t obi_rsp;

    int n_checks;
    int n_errors;

    // subordinate model state
    logic        gnt_s;
    logic        model_rvalid;
    logic [31:0] model_rdata;
    logic        model_err;
    logic        manual_rvalid;
    logic [31:0] manual_rdata;
    bit          suppress_rsp;
    int          err_at;
    int          stall_req;
    int          stall_seen;
    int          stall_changes;
    logic        prev_stall;
    obi_pkg::obi_a_chan_t prev_a;
    int          log_n;
    logic [31:0] log_addr  [0:31];
    logic        log_we    [0:31];
    logic [31:0] log_wdata [0:31];

    user_obi_popcount_mgr dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .num_words_i (num_words_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .result_o    (result_o),
        .obi_req_o   (obi_req),
        .obi_rsp_i   (obi_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h0000_000F;
            32'h0000_1004: return 32'hFFFF_FFFF;
            32'h0000_1008: return 32'h8000_0001;
            32'h0000_4000: return 32'hAAAA_AAAA;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    assign gnt_s = obi_req.req && (stall_seen >= stall_req);

    always_comb begin
        obi_rsp          = '0;
        obi_rsp.gnt      = gnt_s;
        obi_rsp.rvalid   = model_rvalid | manual_rvalid;
        obi_rsp.r.rdata  = manual_rvalid ? manual_rdata : model_rdata;
        obi_rsp.r.err    = model_err & model_rvalid;
    end

    initial begin
        log_n = 0; stall_seen = 0; stall_changes = 0; prev_stall = 1'b0;
        prev_a = '0; model_rvalid = 1'b0; model_rdata = 32'd0; model_err = 1'b0;
    end

    always @(posedge clk) begin
        prev_stall <= obi_req.req && !gnt_s;
        prev_a     <= obi_req.a;
        if (prev_stall && (!obi_req.req || obi_req.a != prev_a))
            stall_changes <= stall_changes + 1;
        if (obi_req.req && !gnt_s)
            stall_seen <= stall_seen + 1;
        if (obi_req.req && gnt_s) begin
            log_addr[log_n]  <= obi_req.a.addr;
            log_we[log_n]    <= obi_req.a.we;
            log_wdata[log_n] <= obi_req.a.wdata;
            log_n            <= log_n + 1;
            model_rvalid     <= !suppress_rsp;
            model_rdata      <= obi_req.a.we ? 32'd0 : mem_word(obi_req.a.addr);
            model_err        <= (log_n == err_at);
        end else begin
            model_rvalid <= 1'b0;
            model_err    <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src_addr_i  = s;
        dst_addr_i  = d;
        num_words_i = n;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    // Returns at the negedge where done_o is high (or after the bound).
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic done_drops(input string tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int b;
        int s0;
        bit seen;
        n_checks = 0; n_errors = 0;
        rst_ni = 1'b0; start_i = 1'b0;
        src_addr_i = 32'd0; dst_addr_i = 32'd0; num_words_i = 16'd0;
        suppress_rsp = 1'b0; err_at = -1; stall_req = 0;
        manual_rvalid = 1'b0; manual_rdata = 32'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_req",    {31'd0, obi_req.req}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o}, 32'd0);
        chk("rst_done",   {31'd0, done_o}, 32'd0);
        chk("rst_err",    {31'd0, err_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // three words: 4 + 32 + 2 = 38 set bits
        b = log_n;
        start_run(32'h1000, 32'h2000, 16'd3);
        chk("t1_busy_rise", {31'd0, busy_o}, 32'd1);
        wait_done("t1");
        chk("t1_result", result_o, 32'h26);
        chk("t1_err", {31'd0, err_o}, 32'd0);
        chk("t1_ntrans", log_n - b, 32'd4);
        chk("t1_rd0_addr", log_addr[b],   32'h1000);
        chk("t1_rd1_addr", log_addr[b+1], 32'h1004);
        chk("t1_rd2_addr", log_addr[b+2], 32'h1008);
        chk("t1_rd_we",    {31'd0, log_we[b+2]}, 32'd0);
        chk("t1_wr_addr",  log_addr[b+3], 32'h2000);
        chk("t1_wr_we",    {31'd0, log_we[b+3]}, 32'd1);
        chk("t1_wr_data",  log_wdata[b+3], 32'h26);
        done_drops("t1");

        // zero words: only the write of 0
        b = log_n;
        start_run(32'h1000, 32'h2000, 16'd0);
        chk("t2_busy_rise", {31'd0, busy_o}, 32'd1);
        wait_done("t2");
        chk("t2_result", result_o, 32'd0);
        chk("t2_ntrans", log_n - b, 32'd1);
        chk("t2_wr_addr", log_addr[b], 32'h2000);
        chk("t2_wr_we",   {31'd0, log_we[b]}, 32'd1);
        chk("t2_wr_data", log_wdata[b], 32'd0);
        done_drops("t2");

        // gnt withheld for 5 cycles on the first read
        b = log_n;
        s0 = stall_seen;
        stall_req = stall_seen + 5;
        start_run(32'h1000, 32'h2000, 16'd3);
        wait_done("t3");
        chk("t3_stall_cycles", stall_seen - s0, 32'd5);
        chk("t3_stall_stable", stall_changes, 32'd0);
        chk("t3_ntrans", log_n - b, 32'd4);
        chk("t3_rd0_addr", log_addr[b], 32'h1000);
        chk("t3_result", result_o, 32'h26);
        done_drops("t3");

        // error on the second read: abort, no write
        b = log_n;
        err_at = b + 1;
        start_run(32'h1000, 32'h2000, 16'd3);
        wait_done("t4");
        chk("t4_err", {31'd0, err_o}, 32'd1);
        done_drops("t4");
        repeat (3) @(negedge clk);
        chk("t4_ntrans", log_n - b, 32'd2);
        chk("t4_err_held", {31'd0, err_o}, 32'd1);
        err_at = -1;

        // start while busy is ignored; start in the DONE cycle is ignored
        b = log_n;
        start_run(32'h1000, 32'h2000, 16'd3);
        chk("t5_err_cleared", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        start_run(32'h4000, 32'h5000, 16'd1);
        wait_done("t5");
        chk("t5_ntrans", log_n - b, 32'd4);
        chk("t5_rd2_addr", log_addr[b+2], 32'h1008);
        chk("t5_wr_addr", log_addr[b+3], 32'h2000);
        chk("t5_wr_data", log_wdata[b+3], 32'h26);
        chk("t5_result", result_o, 32'h26);
        start_run(32'h4000, 32'h5000, 16'd1);
        chk("t5_done_start_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("t5_done_start_req", {31'd0, obi_req.req}, 32'd0);
        chk("t5_done_start_ntrans", log_n - b, 32'd4);

        // reset while waiting for rvalid, stray rvalid afterwards
        b = log_n;
        suppress_rsp = 1'b1;
        start_run(32'h1000, 32'h2000, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (log_n != b) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_read_granted", {31'd0, seen}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_req",    {31'd0, obi_req.req}, 32'd0);
        chk("t6_rst_busy",   {31'd0, busy_o}, 32'd0);
        chk("t6_rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        suppress_rsp = 1'b0;
        @(negedge clk);
        manual_rdata  = 32'hFFFF_FFFF;
        manual_rvalid = 1'b1;
        @(negedge clk);
        manual_rvalid = 1'b0;
        chk("t6_stray_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_stray_done", {31'd0, done_o}, 32'd0);
        chk("t6_stray_req",  {31'd0, obi_req.req}, 32'd0);
        b = log_n;
        start_run(32'h4000, 32'h5000, 16'd1);
        wait_done("t6");
        chk("t6_result", result_o, 32'd16);
        chk("t6_ntrans", log_n - b, 32'd2);
        chk("t6_wr_addr", log_addr[b+1], 32'h5000);
        chk("t6_wr_data", log_wdata[b+1], 32'd16);
        done_drops("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
